// File: rtl/spi_master_ctrl_if.sv
// Command-side handshake and SPI pad signals of the SPI initiator.
// master: the controller; slave: command logic plus the peripheral.
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator, MSB first, full duplex.
// One DATA_W-bit word per accepted start; done pulses with rx_data.
module spi_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    spi_master_ctrl_if.master bus
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                div_tick;
    logic [EDGE_W-1:0]   edge_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        div_tick   = (div_cnt_q == DIV_LAST);
        edge_nxt   = edge_cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_shift_d = bus.tx_data;
                    cs_n_d     = 1'b0;
                    mosi_d     = bus.tx_data[DATA_W-1];
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_tick) begin
                    div_cnt_d  = '0;
                    sclk_d     = 1'b1;
                    edge_cnt_d = EDGE_W'(1);
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.miso};
                    state_d    = XFER;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (div_tick) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = edge_nxt;
                    // odd edge numbers are sclk rises
                    if (edge_nxt[0]) begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (edge_nxt == EDGE_LAST) begin
                            state_d = HOLD;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            mosi_d     = tx_shift_q[DATA_W-2];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_tick) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_shift_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
endmodule
